// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch-stage PC controller.
// Redirect source encoding and the packed instruction-buffer entry layout.
package fetch_pkg;

    localparam int          FETCH_PC_W     = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] FETCH_EXC_VEC  = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_EXC,
        RD_ERET,
        RD_BR
    } redirect_src_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           inst;
        logic                  adel;
    } ibuf_entry_t;

endpackage

// File: rtl/fetch_ibuf.sv
// First-word-fall-through FIFO with synchronous flush; head visible the cycle after push.
// Push while full is accepted only together with a pop; flush overrides push and pop.
module fetch_ibuf #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          out_vld,
    output logic [W-1:0]  out_dat,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_do_pop;
    logic          w_do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_do_pop  = pop_rdy & (r_count != '0);
    assign w_do_push = push_vld & ((r_count != CW'(DEPTH)) | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= ptr_inc(r_wr);
            if (w_do_pop)  r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr] <= push_dat;
    end

    assign out_vld = (r_count != '0);
    assign out_dat = r_mem[r_rd];
    assign count   = r_count;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register, redirect arbitration, SRAM request issue with stale-return cancel, decode buffer.
// Redirect N -> request N+1; data_ok N -> fe_valid N+1; issue stalls while in-flight plus buffered fills the buffer.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W       = FETCH_PC_W,
    parameter logic [PC_W-1:0] RESET_PC   = FETCH_RESET_PC,
    parameter logic [PC_W-1:0] EXC_VEC    = FETCH_EXC_VEC,
    parameter int              MAX_OUTST  = 2,
    parameter int              IBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exc_valid,
    input  logic            eret_valid,
    input  logic [PC_W-1:0] eret_target,
    input  logic            br_valid,
    input  logic [PC_W-1:0] br_target,
    output logic            inst_req,
    output logic [PC_W-1:0] inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [31:0]     inst_rdata,
    output logic            fe_valid,
    output logic [PC_W-1:0] fe_pc,
    output logic [31:0]     fe_inst,
    output logic            fe_adel,
    input  logic            de_allowin
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;
    localparam int EW = PC_W + 32 + 1;

    logic [PC_W-1:0] r_pc;
    logic [OW-1:0]   r_cancel;
    logic            r_adel_done;

    redirect_src_e   w_src;
    logic            w_redirect;
    logic [PC_W-1:0] w_target;
    logic            w_aligned;
    logic [OW-1:0]   w_outst;
    logic [OW-1:0]   w_outst_nxt;
    logic [CW-1:0]   w_ibuf_cnt;
    logic [SW-1:0]   w_occ;
    logic            w_accept;
    logic            w_tag_vld;
    logic [PC_W-1:0] w_tag;
    logic            w_ret;
    logic            w_drop;
    logic            w_ret_push;
    logic            w_adel_push;
    logic            w_ibuf_push;
    logic [EW-1:0]   w_ibuf_din;
    logic            w_ibuf_pop;
    logic            w_head_vld;
    logic [EW-1:0]   w_head;

    always_comb begin
        w_src    = RD_NONE;
        w_target = r_pc;
        if (exc_valid)       w_src = RD_EXC;
        else if (eret_valid) w_src = RD_ERET;
        else if (br_valid)   w_src = RD_BR;
        case (w_src)
            RD_EXC:  w_target = EXC_VEC;
            RD_ERET: w_target = eret_target;
            RD_BR:   w_target = br_target;
            default: w_target = r_pc;
        endcase
    end

    assign w_redirect = (w_src != RD_NONE);
    assign w_aligned  = (r_pc[1:0] == 2'b00);
    assign w_occ      = SW'(w_outst) + SW'(w_ibuf_cnt);

    assign inst_req  = ~reset & w_aligned & (w_outst < OW'(MAX_OUTST))
                     & (w_occ < SW'(IBUF_DEPTH)) & ~w_redirect;
    assign inst_addr = r_pc;
    assign w_accept  = inst_req & inst_addr_ok;

    // A data_ok with nothing in flight is ignored so the counters cannot wrap.
    assign w_ret       = inst_data_ok & w_tag_vld;
    assign w_drop      = w_ret & (r_cancel != '0);
    assign w_outst_nxt = w_outst + OW'(w_accept) - OW'(w_ret);

    // Outstanding is always zero when cancel is, since misalignment only arises from a redirect.
    assign w_adel_push = ~reset & ~w_aligned & ~r_adel_done & ~w_redirect
                       & (r_cancel == '0) & (w_outst == '0) & (w_ibuf_cnt < CW'(IBUF_DEPTH));
    assign w_ret_push  = w_ret & ~w_drop & ~w_redirect;
    assign w_ibuf_push = w_ret_push | w_adel_push;
    assign w_ibuf_din  = w_ret_push ? {w_tag, inst_rdata, 1'b0} : {r_pc, 32'h0, 1'b1};
    assign w_ibuf_pop  = fe_valid & de_allowin & ~w_redirect;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_cancel    <= '0;
            r_adel_done <= 1'b0;
        end else if (w_redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            r_pc        <= w_target;
            r_cancel    <= w_outst_nxt;
            r_adel_done <= 1'b0;
        end else begin
            if (w_accept)    r_pc        <= r_pc + PC_W'(4);
            if (w_drop)      r_cancel    <= r_cancel - OW'(1);
            if (w_adel_push) r_adel_done <= 1'b1;
        end
    end

    fetch_ibuf #(.DEPTH(MAX_OUTST), .W(PC_W), .CW(OW)) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (1'b0),
        .push_vld (w_accept),
        .push_dat (r_pc),
        .pop_rdy  (w_ret),
        .out_vld  (w_tag_vld),
        .out_dat  (w_tag),
        .count    (w_outst)
    );

    fetch_ibuf #(.DEPTH(IBUF_DEPTH), .W(EW), .CW(CW)) u_ibuf (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_redirect),
        .push_vld (w_ibuf_push),
        .push_dat (w_ibuf_din),
        .pop_rdy  (w_ibuf_pop),
        .out_vld  (w_head_vld),
        .out_dat  (w_head),
        .count    (w_ibuf_cnt)
    );

    assign fe_valid = w_head_vld & ~reset;
    assign fe_pc    = w_head[EW-1 -: PC_W];
    assign fe_inst  = w_head[32:1];
    assign fe_adel  = w_head[0] & fe_valid;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a FIFO-ordered SRAM responder driven from the step task.
module tb_fetch_pc_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid, eret_valid, br_valid;
    logic [31:0] eret_target, br_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fe_valid;
    logic [31:0] fe_pc, fe_inst;
    logic        fe_adel;
    logic        de_allowin;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_ret  = 0;
    bit          aok_en, data_en;
    logic [31:0] addr_q[$];
    ibuf_entry_t got_q[$];

    fetch_pc_ctrl dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .eret_valid(eret_valid), .eret_target(eret_target),
        .br_valid(br_valid), .br_target(br_target),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .fe_valid(fe_valid), .fe_pc(fe_pc), .fe_inst(fe_inst), .fe_adel(fe_adel),
        .de_allowin(de_allowin)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkinst(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    // One clock: drive SRAM inputs, record handshakes, advance to posedge+1, drop redirects.
    task automatic step();
        logic [31:0] tmp;
        ibuf_entry_t e;
        inst_addr_ok = aok_en;
        inst_data_ok = data_en && (addr_q.size() != 0);
        inst_rdata   = 32'h0;
        if (inst_data_ok) inst_rdata = mkinst(addr_q[0]);
        #1;
        if (!reset && fe_valid && de_allowin && !(exc_valid || eret_valid || br_valid)) begin
            e.pc = fe_pc; e.inst = fe_inst; e.adel = fe_adel;
            got_q.push_back(e);
        end
        if (inst_data_ok) begin
            tmp = addr_q.pop_front();
            n_ret++;
        end
        if (inst_req && inst_addr_ok) addr_q.push_back(inst_addr);
        @(posedge clk);
        #1;
        exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        aok_en = 1'b0; data_en = 1'b0; de_allowin = 1'b1;
        addr_q.delete();
        step(); step();
        got_q.delete();
        n_ret = 0;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        aok_en = 1'b1; data_en = 1'b1; de_allowin = 1'b1;
        step(); step(); step();
        n_chk++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", inst_req); end
        n_chk++; if (fe_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fe_valid: got %b want 0", fe_valid); end
        n_chk++; if (fe_adel !== 1'b0) begin n_fail++; $display("FAIL reset_fe_adel: got %b want 0", fe_adel); end
        n_chk++; if (inst_addr !== 32'hbfc00000) begin n_fail++; $display("FAIL reset_addr: got %h want bfc00000", inst_addr); end
        reset = 1'b0;
        #1;
        n_chk++; if (inst_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b want 1", inst_req); end
    endtask

    task automatic test_stream();
        do_reset();
        aok_en = 1'b1; data_en = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_chk++; if (got_q.size() < 3) begin n_fail++; $display("FAIL stream_count: got %0d want >=3", got_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (got_q[i].pc !== 32'hbfc00000 + 32'(4*i) || got_q[i].inst !== mkinst(32'hbfc00000 + 32'(4*i)))
                begin n_fail++; $display("FAIL stream_entry%0d: got pc %h inst %h want pc %h", i, got_q[i].pc, got_q[i].inst, 32'hbfc00000 + 32'(4*i)); end
            end
        end
    endtask

    task automatic test_branch_cancel();
        do_reset();
        aok_en = 1'b1; data_en = 1'b0;
        step(); step();
        n_chk++; if (inst_req !== 1'b0) begin n_fail++; $display("FAIL max_outst_req: got %b want 0", inst_req); end
        br_valid = 1'b1; br_target = 32'hbfc00100;
        step();
        n_chk++; if (inst_addr !== 32'hbfc00100) begin n_fail++; $display("FAIL br_addr: got %h want bfc00100", inst_addr); end
        data_en = 1'b1;
        for (int i = 0; i < 12; i++) step();
        n_chk++;
        if (got_q.size() < 1) begin n_fail++; $display("FAIL br_first: got %0d entries want >=1", got_q.size()); end
        else if (got_q[0].pc !== 32'hbfc00100 || got_q[0].inst !== mkinst(32'hbfc00100))
        begin n_fail++; $display("FAIL br_first: got pc %h inst %h want pc bfc00100", got_q[0].pc, got_q[0].inst); end
    endtask

    task automatic test_priority();
        do_reset();
        aok_en = 1'b0;
        exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'hbfc00100;
        step();
        n_chk++; if (inst_addr !== 32'hbfc00380 || inst_req !== 1'b1) begin n_fail++; $display("FAIL exc_over_br: got %h req %b want bfc00380 req 1", inst_addr, inst_req); end
        eret_valid = 1'b1; eret_target = 32'hbfc00200; br_valid = 1'b1; br_target = 32'hbfc00100;
        step();
        n_chk++; if (inst_addr !== 32'hbfc00200) begin n_fail++; $display("FAIL eret_over_br: got %h want bfc00200", inst_addr); end
    endtask

    task automatic test_adel();
        do_reset();
        aok_en = 1'b1; data_en = 1'b1; de_allowin = 1'b0;
        eret_valid = 1'b1; eret_target = 32'hbfc00102;
        step();
        n_chk++; if (inst_req !== 1'b0 || fe_valid !== 1'b0) begin n_fail++; $display("FAIL adel_first: got req %b fe_valid %b want 0 0", inst_req, fe_valid); end
        step();
        n_chk++;
        if (fe_valid !== 1'b1 || fe_adel !== 1'b1 || fe_pc !== 32'hbfc00102 || fe_inst !== 32'h0 || inst_req !== 1'b0)
        begin n_fail++; $display("FAIL adel_entry: got v%b adel%b pc %h inst %h req %b want 1 1 bfc00102 0 0", fe_valid, fe_adel, fe_pc, fe_inst, inst_req); end
        de_allowin = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_chk++; if (fe_valid !== 1'b0 || inst_req !== 1'b0 || got_q.size() != 1)
        begin n_fail++; $display("FAIL adel_once: got v%b req %b n %0d want 0 0 1", fe_valid, inst_req, got_q.size()); end
    endtask

    task automatic test_stall();
        do_reset();
        aok_en = 1'b1; data_en = 1'b1; de_allowin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_chk++;
            if (addr_q.size() + n_ret > 2) begin n_fail++; $display("FAIL stall_occ%0d: got %0d want <=2", i, addr_q.size() + n_ret); end
        end
        n_chk++; if (fe_valid !== 1'b1 || fe_pc !== 32'hbfc00000) begin n_fail++; $display("FAIL stall_head: got v%b pc %h want 1 bfc00000", fe_valid, fe_pc); end
        de_allowin = 1'b1;
        for (int i = 0; i < 20; i++) step();
        n_chk++; if (got_q.size() < 5) begin n_fail++; $display("FAIL stall_release_n: got %0d want >=5", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_chk++;
            if (got_q[i].pc !== 32'hbfc00000 + 32'(4*i) || got_q[i].inst !== mkinst(32'hbfc00000 + 32'(4*i)))
            begin n_fail++; $display("FAIL stall_seq%0d: got pc %h want %h", i, got_q[i].pc, 32'hbfc00000 + 32'(4*i)); end
        end
    endtask

    task automatic test_coincident();
        do_reset();
        aok_en = 1'b1; data_en = 1'b1; de_allowin = 1'b1;
        step(); step();
        br_valid = 1'b1; br_target = 32'hbfc00200;
        step();
        n_chk++; if (fe_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00200)
        begin n_fail++; $display("FAIL coinc_after: got v%b req %b addr %h want 0 1 bfc00200", fe_valid, inst_req, inst_addr); end
        for (int i = 0; i < 10; i++) step();
        n_chk++;
        if (got_q.size() < 1) begin n_fail++; $display("FAIL coinc_first: got %0d entries want >=1", got_q.size()); end
        else if (got_q[0].pc !== 32'hbfc00200) begin n_fail++; $display("FAIL coinc_first: got %h want bfc00200", got_q[0].pc); end
    endtask

    initial begin
        reset = 1'b1;
        exc_valid = 1'b0; eret_valid = 1'b0; br_valid = 1'b0;
        eret_target = 32'h0; br_target = 32'h0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        de_allowin = 1'b1; aok_en = 1'b0; data_en = 1'b0;
        test_reset();
        test_stream();
        test_branch_cancel();
        test_priority();
        test_adel();
        test_stall();
        test_coincident();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
